// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with 3-sample majority vote and error reporting
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int H = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_S0  = TW'(H - 1);
  localparam logic [TW-1:0] T_S1  = TW'(H);
  localparam logic [TW-1:0] T_MID = TW'(H + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);
  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] PAR       = 3'd4;
  localparam logic [2:0] STOP      = 3'd5;

  logic [1:0]           sync_q, sync_d, settle_q, settle_d, samp_q, samp_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic                 par_q, par_d, stop0_q, stop0_d, stop1_q, stop1_d;
  logic                 rx_done_q, rx_done_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, break_det_q, break_det_d;
  logic                 rxs, maj, mid, last, bad, perr;

  // all state lives here; the synchronizer comes up at the idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b11;
      settle_q     <= '0;
      samp_q       <= '0;
      state_q      <= WAIT_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop0_q      <= 1'b0;
      stop1_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      settle_q     <= settle_d;
      samp_q       <= samp_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop0_q      <= stop0_d;
      stop1_q      <= stop1_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rxs  = sync_q[1];
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign mid  = tick && tick_cnt_q == T_MID;
  assign last = tick && tick_cnt_q == T_END;
  assign bad  = stop0_q | ~maj;
  assign perr = PARITY == 1 ? ~(^shift_q ^ par_q) : PARITY == 2 ? (^shift_q ^ par_q) : 1'b0;

  // frame sequencing; WAIT_IDLE ignores rxs until the reset value of the synchronizer has flushed out
  always_comb begin
    sync_d       = {sync_q[0], rx};
    settle_d     = {settle_q[0], 1'b1};
    samp_d       = samp_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop0_d      = stop0_q;
    stop1_d      = stop1_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    if (state_q == WAIT_IDLE) begin
      if (settle_q[1] && rxs) state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (!rxs) begin
        state_d    = START;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        par_d      = 1'b0;
        stop0_d    = 1'b0;
        stop1_d    = 1'b0;
      end
    end else if (tick) begin
      tick_cnt_d = last ? '0 : tick_cnt_q + TW'(1);
      if (tick_cnt_q == T_S0) samp_d[0] = rxs;
      if (tick_cnt_q == T_S1) samp_d[1] = rxs;
      case (state_q)
        START: begin
          if (mid && maj) state_d = IDLE;
          else if (last) state_d = DATA;
        end
        DATA: begin
          if (mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (last) begin
            bit_cnt_d = bit_cnt_q == D_LAST ? 4'd0 : bit_cnt_q + 4'd1;
            if (bit_cnt_q == D_LAST) state_d = PARITY != 0 ? PAR : STOP;
          end
        end
        PAR: begin
          if (mid) par_d = maj;
          if (last) state_d = STOP;
        end
        STOP: begin
          if (mid) begin
            stop0_d = stop0_q | ~maj;
            stop1_d = stop1_q | maj;
          end
          if (mid && bit_cnt_q == S_LAST) begin
            rx_done_d    = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = perr;
            frame_err_d  = bad;
            break_det_d  = shift_q == '0 && !par_q && !stop1_q && !maj;
            state_d      = bad ? WAIT_IDLE : IDLE;
            tick_cnt_d   = '0;
          end else if (last) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = WAIT_IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
endmodule
